// File: rtl/cpu_pkg.sv
// Shared CPU-wide definitions: datapath width and the PC/instruction types.
package cpu_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] pc_t;
  typedef logic [XLEN-1:0] insn_t;
endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the instruction-memory request/response, redirect and decode handshakes.
interface fetch_queue_if #(
  parameter int XLEN = cpu_pkg::XLEN
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_insn;
  logic [XLEN-1:0] dec_pc;

  // master: the fetch queue itself; slave: memory + redirect source + decode
  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_insn, dec_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, dec_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_insn, dec_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fq_entry_ram.sv
// Fetch-queue entry storage: pc/insn arrays plus per-entry pending/filled flags.
module fq_entry_ram #(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            alloc_i,
  input  logic [PW-1:0]   alloc_idx_i,
  input  logic [XLEN-1:0] alloc_pc_i,
  input  logic            fill_i,
  input  logic [PW-1:0]   fill_idx_i,
  input  logic [XLEN-1:0] fill_data_i,
  input  logic            free_i,
  input  logic [PW-1:0]   free_idx_i,
  input  logic [PW-1:0]   rd_idx_i,
  output logic [XLEN-1:0] rd_pc_o,
  output logic [XLEN-1:0] rd_insn_o,
  output logic            rd_filled_o,
  output logic            fill_pending_o
);
  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic [XLEN-1:0]  insn_mem [DEPTH];
  logic [DEPTH-1:0] pending_q, pending_d;
  logic [DEPTH-1:0] filled_q, filled_d;

  always_ff @(posedge clk) begin
    if (alloc_i) pc_mem[alloc_idx_i] <= alloc_pc_i;
    if (fill_i)  insn_mem[fill_idx_i] <= fill_data_i;
  end

  // A free beats a fill on the same entry: that is the bypassed dequeue.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic hit_alloc, hit_fill, hit_free;
    assign hit_alloc = alloc_i && (alloc_idx_i == PW'(gi));
    assign hit_fill  = fill_i  && (fill_idx_i  == PW'(gi));
    assign hit_free  = free_i  && (free_idx_i  == PW'(gi));
    assign pending_d[gi] = clr_i ? 1'b0 : hit_alloc ? 1'b1 :
                           (hit_free || hit_fill) ? 1'b0 : pending_q[gi];
    assign filled_d[gi]  = clr_i ? 1'b0 : hit_alloc ? 1'b0 :
                           hit_free ? 1'b0 : hit_fill ? 1'b1 : filled_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      filled_q  <= '0;
    end else begin
      pending_q <= pending_d;
      filled_q  <= filled_d;
    end
  end

  assign rd_pc_o        = pc_mem[rd_idx_i];
  assign rd_insn_o      = insn_mem[rd_idx_i];
  assign rd_filled_o    = filled_q[rd_idx_i];
  assign fill_pending_o = pending_q[fill_idx_i];
endmodule

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue with redirect flush and stale-response dropping.
// Optional macro FETCH_QUEUE_BYPASS_EN forwards a fill of the head entry to decode in the same cycle.
module fetch_queue #(
  parameter int XLEN     = cpu_pkg::XLEN,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 1,
  parameter int RESET_PC = 0
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d, fill_ptr_q, fill_ptr_d;
  logic [CW-1:0]   count_q, count_d, pend_cnt_q, pend_cnt_d, drop_cnt_q, drop_cnt_d;
  logic            post_rst_q;

  logic            full, req_valid, alloc, resp_take, drop_hit, fill, bypass, deq;
  logic            dec_valid, head_filled, fill_pending;
  logic [XLEN-1:0] head_pc, head_insn;
  logic [CW:0]     drop_sum;
  logic [CW-1:0]   drop_redir;

  assign full      = (count_q == CW'(DEPTH));
  assign req_valid = !rst && !full && !bus.redirect_valid;
  assign alloc     = req_valid && bus.imem_req_ready;
  // The first response after reset release belongs to a request issued before reset.
  assign resp_take = bus.imem_resp_valid && !rst && !bus.redirect_valid && !post_rst_q;
  assign drop_hit  = resp_take && (drop_cnt_q != '0);
  assign fill      = resp_take && (drop_cnt_q == '0) && fill_pending;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = fill && (fill_ptr_q == head_q);
`else
  assign bypass = 1'b0;
`endif

  assign dec_valid = !rst && !bus.redirect_valid && (head_filled || bypass);
  assign deq       = dec_valid && bus.dec_ready;

  // Responses still in flight at a redirect, minus one already arriving now.
  always_comb begin
    drop_sum = {1'b0, pend_cnt_q} + {1'b0, drop_cnt_q};
    if (bus.imem_resp_valid && (drop_sum != '0)) drop_sum = drop_sum - (CW+1)'(1);
    drop_redir = (drop_sum > (CW+1)'(DEPTH)) ? CW'(DEPTH) : drop_sum[CW-1:0];
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_ptr_d = fill_ptr_q;
    count_d    = count_q;
    pend_cnt_d = pend_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
      head_d     = '0;
      tail_d     = '0;
      fill_ptr_d = '0;
      count_d    = '0;
      pend_cnt_d = '0;
      drop_cnt_d = drop_redir;
    end else begin
      if (alloc) begin
        fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        tail_d     = tail_q + PW'(1);
      end
      if (fill)     fill_ptr_d = fill_ptr_q + PW'(1);
      if (deq)      head_d     = head_q + PW'(1);
      if (drop_hit) drop_cnt_d = drop_cnt_q - CW'(1);
      count_d    = count_q + CW'(alloc) - CW'(deq);
      pend_cnt_d = pend_cnt_q + CW'(alloc) - CW'(fill);
    end
  end

  always_ff @(posedge clk) begin
    post_rst_q <= rst;
    if (rst) begin
      fetch_pc_q <= XLEN'(RESET_PC);
      head_q     <= '0;
      tail_q     <= '0;
      fill_ptr_q <= '0;
      count_q    <= '0;
      pend_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_ptr_q <= fill_ptr_d;
      count_q    <= count_d;
      pend_cnt_q <= pend_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fq_entry_ram #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_entry_ram (
    .clk            (clk),
    .rst            (rst),
    .clr_i          (bus.redirect_valid),
    .alloc_i        (alloc),
    .alloc_idx_i    (tail_q),
    .alloc_pc_i     (fetch_pc_q),
    .fill_i         (fill),
    .fill_idx_i     (fill_ptr_q),
    .fill_data_i    (bus.imem_resp_data),
    .free_i         (deq),
    .free_idx_i     (head_q),
    .rd_idx_i       (head_q),
    .rd_pc_o        (head_pc),
    .rd_insn_o      (head_insn),
    .rd_filled_o    (head_filled),
    .fill_pending_o (fill_pending)
  );

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.dec_valid      = dec_valid;
  assign bus.dec_pc         = head_pc;
  assign bus.dec_insn       = bypass ? bus.imem_resp_data : head_insn;
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4: queue entries, power of two, minimum 2.
REQ-003 SHALL have parameter PC_STEP, default 1: PC increment per fetch (word addressing).
REQ-004 SHALL have parameter RESET_PC, default 0: first fetch address.
REQ-005 SHALL have port clk, input, 1 bit: clock; all state updates on posedge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port imem_req_valid, output, 1 bit: fetch request.
REQ-008 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-009 SHALL have port imem_req_addr, output, XLEN bits: fetch address.
REQ-010 SHALL have port imem_resp_valid, input, 1 bit: response strobe; responses return in request order with latency of 1 or more cycles.
REQ-011 SHALL have port imem_resp_data, input, XLEN bits: fetched instruction.
REQ-012 SHALL have port redirect_valid, input, 1 bit: flush and restart.
REQ-013 SHALL have port redirect_pc, input, XLEN bits: restart address.
REQ-014 SHALL have port dec_valid, output, 1 bit: head instruction available.
REQ-015 SHALL have port dec_ready, input, 1 bit: decode consumes the head.
REQ-016 SHALL have port dec_insn, output, XLEN bits: head instruction.
REQ-017 SHALL have port dec_pc, output, XLEN bits: PC of the head instruction.

Function
REQ-018 SHALL hold a fetch PC register; imem_req_addr SHALL equal the fetch PC.
REQ-019 SHALL drive imem_req_valid = (count < DEPTH) && !redirect_valid; count is the number of allocated entries, pending or filled.
REQ-020 SHALL, on request handshake, allocate the tail entry: store the PC, mark it pending, tail+1 mod DEPTH, fetch PC += PC_STEP (wraps modulo 2^XLEN).
REQ-021 SHALL, on imem_resp_valid with drop_cnt > 0, discard the response and decrement drop_cnt.
REQ-022 SHALL, on imem_resp_valid with drop_cnt == 0, write the data into the oldest pending entry and mark it filled.
REQ-023 SHALL drive dec_valid = head entry allocated and filled; dec_insn and dec_pc SHALL come from the head entry.
REQ-024 SHALL, on dec_valid && dec_ready, free the head entry (head+1 mod DEPTH).
REQ-025 SHALL permit allocate, fill and dequeue in the same cycle; count updates by (alloc - dequeue).
REQ-026 SHALL not allocate when full, even if a dequeue occurs in the same cycle.
REQ-027 SHALL, on redirect_valid, in priority over all other events: clear every entry (count=0, head=tail), set fetch PC to redirect_pc, and set drop_cnt to (pending entries + drop_cnt - imem_resp_valid).
REQ-028 SHALL, in the redirect cycle, discard any response, perform no dequeue, and drive dec_valid low.
REQ-029 SHALL size drop_cnt and count at $clog2(DEPTH+1) bits; drop_cnt SHALL never exceed DEPTH.

Reset
REQ-030 SHALL, in a cycle with rst high, set fetch PC=RESET_PC, head=tail=0, count=0, drop_cnt=0, and all entries invalid.
REQ-031 SHALL hold imem_req_valid=0 and dec_valid=0 while rst is high; rst SHALL override redirect_valid.
REQ-032 SHALL discard a response that arrives in the first cycle after reset is released.

Configuration
REQ-033 SHALL honour the macro FETCH_QUEUE_BYPASS_EN.
REQ-034 SHALL, with the macro defined: when the head entry is pending and a fill arrives for it, assert dec_valid combinationally in that cycle, with dec_insn = imem_resp_data.
REQ-035 SHALL, with the macro defined and dec_ready high in that cycle, free the entry directly.
REQ-036 SHALL, without the macro, make filled data visible on dec_valid no earlier than the next cycle.

Structure
REQ-037 SHALL take the XLEN default and the pc_t and insn_t typedefs from the shared cpu_pkg.
REQ-038 SHALL keep entry storage (pc, insn, pending, filled) in a single sub-module fq_entry_ram, indexed by head, tail and fill pointers.

Verification
REQ-039 SHALL cover: after reset, ready=1, responses 1 cycle later with data 0xA0+n -> dec_pc sequence 0,1,2,3, insns 0xA0..0xA3 in order.
REQ-040 SHALL cover: dec_ready=0, DEPTH=4 -> exactly 4 requests (addresses 0..3), then imem_req_valid=0 until the first dequeue.
REQ-041 SHALL cover: redirect to 0x40 with 2 pending -> the next 2 responses are dropped, the next dec_pc is 0x40, and no stale data appears.
REQ-042 SHALL cover: redirect coinciding with a response -> that response is dropped, drop_cnt = pending-1, and the first post-redirect insn is correct.
REQ-043 SHALL cover: with BYPASS_EN, an empty queue and a 1-cycle response -> dec_valid in the response cycle; without BYPASS_EN -> dec_valid one cycle later.
REQ-044 SHALL cover: rst asserted mid-stream with 3 entries -> the next cycle has count=0 and imem_req_addr=RESET_PC, and the late response is dropped.
